// File: rtl/unidade_controle_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo_if
// Description : Control/datapath bus between the multicycle MIPS controller
//               and the 32-bit ULA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface unidade_controle_multiciclo_if #(
  parameter int LARGURA_ESTADO = 4
);
  logic [5:0]                op;
  logic [5:0]                funct;
  logic                      zero;
  logic                      overflow;
  logic                      IorD;
  logic                      MemWrite;
  logic                      IRWrite;
  logic                      RegDst;
  logic                      MemtoReg;
  logic                      RegWrite;
  logic                      ULAfonteA;
  logic [1:0]                ULAfonteB;
  logic [2:0]                ULAcontrole;
  logic [1:0]                PCSrc;
  logic                      PCEn;
  logic                      excecao;
  logic [LARGURA_ESTADO-1:0] estado;

  modport master (
    input  op, funct, zero, overflow,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULAfonteA, ULAfonteB, ULAcontrole, PCSrc, PCEn, excecao, estado
  );

  modport slave (
    output op, funct, zero, overflow,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ULAfonteA, ULAfonteB, ULAcontrole, PCSrc, PCEn, excecao, estado
  );
endinterface
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Multicycle MIPS control FSM (lw/sw/R-type/addi/beq/j) driving
//               the ULA datapath, with overflow/illegal-instruction exception.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo #(
  parameter int LARGURA_ESTADO = 4
) (
  input  wire logic                         clk,
  input  wire logic                         reset_n,
  unidade_controle_multiciclo_if.master     ctrl
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [2:0] c_ula_add = 3'b010;
  localparam logic [2:0] c_ula_sub = 3'b110;
  localparam logic [2:0] c_ula_and = 3'b000;
  localparam logic [2:0] c_ula_or  = 3'b001;
  localparam logic [2:0] c_ula_slt = 3'b111;

  typedef enum logic [LARGURA_ESTADO-1:0] {
    S_RESET    = LARGURA_ESTADO'(0),
    S_FETCH    = LARGURA_ESTADO'(1),
    S_DECODE   = LARGURA_ESTADO'(2),
    S_MEMADR   = LARGURA_ESTADO'(3),
    S_MEMREAD  = LARGURA_ESTADO'(4),
    S_MEMWB    = LARGURA_ESTADO'(5),
    S_MEMWRITE = LARGURA_ESTADO'(6),
    S_EXECUTE  = LARGURA_ESTADO'(7),
    S_ALUWB    = LARGURA_ESTADO'(8),
    S_BRANCH   = LARGURA_ESTADO'(9),
    S_ADDIEXEC = LARGURA_ESTADO'(10),
    S_ADDIWB   = LARGURA_ESTADO'(11),
    S_JUMP     = LARGURA_ESTADO'(12),
    S_OVF      = LARGURA_ESTADO'(13),
    S_ILEGAL   = LARGURA_ESTADO'(14)
  } estado_t;

  estado_t    r_estado;
  estado_t    w_proximo;
  logic       r_excecao;

  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_fonte_a;
  logic [1:0] w_fonte_b;
  logic [2:0] w_ula_ctl;
  logic [1:0] w_pcsrc;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_funct_ok;
  logic       w_aritmetica;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado  <= S_RESET;
      r_excecao <= 1'b0;
    end else begin
      r_estado  <= w_proximo;
      r_excecao <= (w_proximo == S_OVF) || (w_proximo == S_ILEGAL);
    end
  end

  // R-type funct decode; only add/sub can raise an arithmetic exception
  always_comb begin
    w_ula_ctl    = c_ula_add;
    w_funct_ok   = 1'b1;
    w_aritmetica = 1'b0;
    case (ctrl.funct)
      6'b100000: begin w_ula_ctl = c_ula_add; w_aritmetica = 1'b1; end
      6'b100010: begin w_ula_ctl = c_ula_sub; w_aritmetica = 1'b1; end
      6'b100100: w_ula_ctl = c_ula_and;
      6'b100101: w_ula_ctl = c_ula_or;
      6'b101010: w_ula_ctl = c_ula_slt;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_proximo  = r_estado;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_fonte_a  = 1'b0;
    w_fonte_b  = 2'b00;
    ctrl.ULAcontrole = 3'b000;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_estado)
      S_RESET: w_proximo = S_FETCH;
      S_FETCH: begin
        w_irwrite        = 1'b1;
        w_fonte_b        = 2'b01;
        ctrl.ULAcontrole = c_ula_add;
        w_pcwrite        = 1'b1;
        w_proximo        = S_DECODE;
      end
      S_DECODE: begin
        w_fonte_b        = 2'b11;
        ctrl.ULAcontrole = c_ula_add;
        case (ctrl.op)
          c_op_lw, c_op_sw: w_proximo = S_MEMADR;
          c_op_rtype:       w_proximo = S_EXECUTE;
          c_op_beq:         w_proximo = S_BRANCH;
          c_op_addi:        w_proximo = S_ADDIEXEC;
          c_op_j:           w_proximo = S_JUMP;
          default:          w_proximo = S_ILEGAL;
        endcase
      end
      S_MEMADR: begin
        w_fonte_a        = 1'b1;
        w_fonte_b        = 2'b10;
        ctrl.ULAcontrole = c_ula_add;
        w_proximo        = (ctrl.op == c_op_sw) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_iord    = 1'b1;
        w_proximo = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_proximo  = S_FETCH;
      end
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_proximo  = S_FETCH;
      end
      S_EXECUTE: begin
        w_fonte_a        = 1'b1;
        ctrl.ULAcontrole = w_ula_ctl;
        if (!w_funct_ok)
          w_proximo = S_ILEGAL;
        else if (w_aritmetica && ctrl.overflow)
          w_proximo = S_OVF;
        else
          w_proximo = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_proximo  = S_FETCH;
      end
      S_BRANCH: begin
        w_fonte_a        = 1'b1;
        ctrl.ULAcontrole = c_ula_sub;
        w_pcsrc          = 2'b01;
        w_branch         = 1'b1;
        w_proximo        = S_FETCH;
      end
      S_ADDIEXEC: begin
        w_fonte_a        = 1'b1;
        w_fonte_b        = 2'b10;
        ctrl.ULAcontrole = c_ula_add;
        w_proximo        = ctrl.overflow ? S_OVF : S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_proximo  = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_proximo = S_FETCH;
      end
      S_OVF, S_ILEGAL: w_proximo = S_FETCH;
      default:         w_proximo = S_RESET;
    endcase
  end

  assign ctrl.IorD      = w_iord;
  assign ctrl.MemWrite  = w_memwrite;
  assign ctrl.IRWrite   = w_irwrite;
  assign ctrl.RegDst    = w_regdst;
  assign ctrl.MemtoReg  = w_memtoreg;
  assign ctrl.RegWrite  = w_regwrite;
  assign ctrl.ULAfonteA = w_fonte_a;
  assign ctrl.ULAfonteB = w_fonte_b;
  assign ctrl.PCSrc     = w_pcsrc;
  assign ctrl.PCEn      = w_pcwrite | (w_branch & ctrl.zero);
  assign ctrl.excecao   = r_excecao;
  assign ctrl.estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_multiciclo
// Description : Table-driven per-cycle check of the multicycle control FSM,
//               plus a reset-abort sequence during MEMREAD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unidade_controle_multiciclo;

  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ULAfonteA,ULAfonteB,ULAcontrole,PCSrc,PCEn,excecao}
  localparam logic [15:0] c_rst  = 16'b0_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] c_fet  = 16'b0_0_1_0_0_0_0_01_010_00_1_0;
  localparam logic [15:0] c_dec  = 16'b0_0_0_0_0_0_0_11_010_00_0_0;
  localparam logic [15:0] c_madr = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [15:0] c_mrd  = 16'b1_0_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] c_mwb  = 16'b0_0_0_0_1_1_0_00_000_00_0_0;
  localparam logic [15:0] c_mwr  = 16'b1_1_0_0_0_0_0_00_000_00_0_0;
  localparam logic [15:0] c_eadd = 16'b0_0_0_0_0_0_1_00_010_00_0_0;
  localparam logic [15:0] c_esub = 16'b0_0_0_0_0_0_1_00_110_00_0_0;
  localparam logic [15:0] c_eand = 16'b0_0_0_0_0_0_1_00_000_00_0_0;
  localparam logic [15:0] c_eor  = 16'b0_0_0_0_0_0_1_00_001_00_0_0;
  localparam logic [15:0] c_eslt = 16'b0_0_0_0_0_0_1_00_111_00_0_0;
  localparam logic [15:0] c_awb  = 16'b0_0_0_1_0_1_0_00_000_00_0_0;
  localparam logic [15:0] c_br1  = 16'b0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [15:0] c_br0  = 16'b0_0_0_0_0_0_1_00_110_01_0_0;
  localparam logic [15:0] c_aiex = 16'b0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [15:0] c_aiwb = 16'b0_0_0_0_0_1_0_00_000_00_0_0;
  localparam logic [15:0] c_jmp  = 16'b0_0_0_0_0_0_0_00_000_10_1_0;
  localparam logic [15:0] c_exc  = 16'b0_0_0_0_0_0_0_00_000_00_0_1;

  localparam logic [5:0] c_r = 6'b000000, c_lw = 6'b100011, c_sw = 6'b101011;
  localparam logic [5:0] c_beq = 6'b000100, c_addi = 6'b001000, c_j = 6'b000010;
  localparam logic [5:0] c_bad = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ovf;
    logic [3:0]  est;
    logic [15:0] ctl;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  int     checks = 0;
  int     errors = 0;
  logic   abort_win = 1'b0;
  logic   regw_seen = 1'b0;
  vec_t   tv[$];

  unidade_controle_multiciclo_if #(.LARGURA_ESTADO(4)) bus ();

  unidade_controle_multiciclo #(.LARGURA_ESTADO(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  wire logic [15:0] w_ctl = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
                             bus.MemtoReg, bus.RegWrite, bus.ULAfonteA, bus.ULAfonteB,
                             bus.ULAcontrole, bus.PCSrc, bus.PCEn, bus.excecao};

  always @(posedge clk) if (abort_win && bus.RegWrite) regw_seen = 1'b1;

  task automatic row(input logic [5:0] op, input logic [5:0] funct, input logic z,
                     input logic ov, input logic [3:0] est, input logic [15:0] ctl);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = z; v.ovf = ov; v.est = est; v.ctl = ctl;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] est, input logic [15:0] ctl);
    checks++;
    if (bus.estado !== est) begin
      errors++;
      $display("FAIL %s estado: got %0d expected %0d", name, bus.estado, est);
    end
    checks++;
    if (w_ctl !== ctl) begin
      errors++;
      $display("FAIL %s controls: got %b expected %b", name, w_ctl, ctl);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.op = v.op; bus.funct = v.funct; bus.zero = v.zero; bus.overflow = v.ovf;
  endtask

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.overflow = 1'b0;

    row(c_r,    6'd0,      0, 0, 4'd0,  c_rst);
    // lw with overflow set during address calc (must be ignored)
    row(c_lw,   6'd0,      0, 0, 4'd1,  c_fet);
    row(c_lw,   6'd0,      0, 0, 4'd2,  c_dec);
    row(c_lw,   6'd0,      0, 1, 4'd3,  c_madr);
    row(c_lw,   6'd0,      0, 0, 4'd4,  c_mrd);
    row(c_lw,   6'd0,      0, 0, 4'd5,  c_mwb);
    row(c_sw,   6'd0,      0, 0, 4'd1,  c_fet);
    row(c_sw,   6'd0,      0, 0, 4'd2,  c_dec);
    row(c_sw,   6'd0,      0, 0, 4'd3,  c_madr);
    row(c_sw,   6'd0,      0, 0, 4'd6,  c_mwr);
    row(c_r,    6'b100010, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b100010, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b100010, 0, 0, 4'd7,  c_esub);
    row(c_r,    6'b100010, 1, 0, 4'd8,  c_awb);
    row(c_r,    6'b100100, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b100100, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b100100, 0, 1, 4'd7,  c_eand);
    row(c_r,    6'b100100, 0, 0, 4'd8,  c_awb);
    row(c_r,    6'b100101, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b100101, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b100101, 0, 0, 4'd7,  c_eor);
    row(c_r,    6'b100101, 0, 0, 4'd8,  c_awb);
    row(c_r,    6'b101010, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b101010, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b101010, 0, 1, 4'd7,  c_eslt);
    row(c_r,    6'b101010, 0, 0, 4'd8,  c_awb);
    row(c_r,    6'b100000, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b100000, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b100000, 0, 1, 4'd7,  c_eadd);
    row(c_r,    6'b100000, 0, 0, 4'd13, c_exc);
    row(c_r,    6'b100000, 0, 0, 4'd1,  c_fet);
    row(c_r,    6'b100000, 0, 0, 4'd2,  c_dec);
    row(c_r,    6'b100000, 0, 0, 4'd7,  c_eadd);
    row(c_r,    6'b100000, 0, 0, 4'd8,  c_awb);
    row(c_addi, 6'd0,      0, 0, 4'd1,  c_fet);
    row(c_addi, 6'd0,      0, 0, 4'd2,  c_dec);
    row(c_addi, 6'd0,      0, 1, 4'd10, c_aiex);
    row(c_addi, 6'd0,      0, 0, 4'd13, c_exc);
    row(c_addi, 6'd0,      0, 0, 4'd1,  c_fet);
    row(c_addi, 6'd0,      0, 0, 4'd2,  c_dec);
    row(c_addi, 6'd0,      0, 0, 4'd10, c_aiex);
    row(c_addi, 6'd0,      0, 0, 4'd11, c_aiwb);
    row(c_beq,  6'd0,      1, 0, 4'd1,  c_fet);
    row(c_beq,  6'd0,      1, 0, 4'd2,  c_dec);
    row(c_beq,  6'd0,      1, 0, 4'd9,  c_br1);
    row(c_beq,  6'd0,      0, 0, 4'd1,  c_fet);
    row(c_beq,  6'd0,      0, 0, 4'd2,  c_dec);
    row(c_beq,  6'd0,      0, 1, 4'd9,  c_br0);
    row(c_j,    6'd0,      0, 0, 4'd1,  c_fet);
    row(c_j,    6'd0,      0, 0, 4'd2,  c_dec);
    row(c_j,    6'd0,      0, 0, 4'd12, c_jmp);
    row(c_bad,  6'd0,      0, 0, 4'd1,  c_fet);
    row(c_bad,  6'd0,      0, 0, 4'd2,  c_dec);
    row(c_bad,  6'd0,      0, 0, 4'd14, c_exc);
    row(c_r,    6'd0,      0, 0, 4'd1,  c_fet);

    repeat (2) @(negedge clk);
    #1;
    check("in_reset", 4'd0, c_rst);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      #1;
      check($sformatf("row%0d", i), tv[i].est, tv[i].ctl);
      @(negedge clk);
    end

    // reset abort in the middle of lw
    reset_n = 1'b0;
    #1;
    check("reset_mid_decode", 4'd0, c_rst);
    @(negedge clk);
    reset_n = 1'b1;
    bus.op = c_lw; bus.funct = '0; bus.zero = 1'b0; bus.overflow = 1'b0;
    #1; check("abort_reset", 4'd0, c_rst);  @(negedge clk);
    #1; check("abort_fetch", 4'd1, c_fet);  @(negedge clk);
    #1; check("abort_decode", 4'd2, c_dec); @(negedge clk);
    #1; check("abort_memadr", 4'd3, c_madr); @(negedge clk);
    #1; check("abort_memread", 4'd4, c_mrd);
    abort_win = 1'b1;
    #1 reset_n = 1'b0;
    #1; check("abort_immediate", 4'd0, c_rst);
    repeat (2) @(negedge clk);
    #1; check("abort_held", 4'd0, c_rst);
    reset_n = 1'b1;
    @(negedge clk);
    #1; check("abort_refetch", 4'd1, c_fet);
    abort_win = 1'b0;
    checks++;
    if (regw_seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_regwrite: got %b expected 0", regw_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
